// File: rtl/stdrst_pkg.sv
// -----------------------------------------------------------------------------
// stdrst_pkg
//   Shared types and elaboration-time helpers for the staged reset controller.
//   - stdrst_state_t : sequencer states (ASSERT, REL, RUN)
//   - clog2_min1     : counter width for a value range, never narrower than 1
//   - max2           : larger of two integers, for sizing shared counters
// -----------------------------------------------------------------------------
package stdrst_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,  // all channels held in reset, stretch counter running
    REL    = 2'd1,  // channels being released one by one
    RUN    = 2'd2   // everything released; software resets accepted
  } stdrst_state_t;

  function automatic int unsigned clog2_min1(input int unsigned value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stdrst_sync.sv
// -----------------------------------------------------------------------------
// stdrst_sync
//   Multi-flop bit synchroniser bringing an asynchronous level into the clk
//   domain. All flops clear to 0 on the synchronous active-high reset.
// Parameters
//   STAGES : number of flops in the chain (>= 2)
// Ports
//   clk : sampling clock
//   rst : synchronous active-high reset
//   d   : asynchronous input level
//   q   : synchronised level, STAGES edges behind d
// -----------------------------------------------------------------------------
module stdrst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/stdrst_seq.sv
// -----------------------------------------------------------------------------
// stdrst_seq
//   Staged reset controller. Conditions the global reset and an asynchronous
//   external reset request into NCH active-low per-subsystem resets, released
//   in index order (ch0 first) once the source has been gone for STRETCH
//   cycles, with GAP cycles between successive channels. In RUN, each channel
//   can additionally be pulsed into reset for SW_HOLD cycles by software.
//
// Parameters
//   NCH         : number of reset output channels (>= 1)
//   STRETCH     : cycles all channels stay low after the reset source drops
//   GAP         : cycles between successive channel releases
//   SYNC_STAGES : synchroniser depth for i_rst_req (>= 2)
//   SW_HOLD     : cycles a software-reset channel stays low
//   FILT_LEN    : consecutive synchronised-high cycles required on i_rst_req
//                 (exists only when STDRST_GLITCH_FILT_EN is defined)
//
// Configuration
//   STDRST_GLITCH_FILT_EN : when defined, a synchronised request must stay high
//   for FILT_LEN consecutive cycles before it acts. When undefined, a single
//   synchronised high cycle forces ASSERT and no filter logic exists.
//
// Ports
//   clk       : single clock, all logic on posedge
//   rst       : synchronous active-high global reset
//   i_rst_req : asynchronous active-high external reset request
//   i_sw_rst  : per-channel software reset pulse (synchronous, active-high)
//   o_rst_n   : per-channel registered active-low reset
//   o_busy    : high while in ASSERT or REL
//   o_done    : one-cycle pulse on entry to RUN
// -----------------------------------------------------------------------------
module stdrst_seq
  import stdrst_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int STRETCH     = 4,
  parameter int GAP         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SW_HOLD     = 8
`ifdef STDRST_GLITCH_FILT_EN
  ,
  parameter int FILT_LEN    = 3
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_rst_req,
  input  logic [NCH-1:0] i_sw_rst,
  output logic [NCH-1:0] o_rst_n,
  output logic           o_busy,
  output logic           o_done
);

  // One counter serves both the stretch and the gap phases.
  localparam int CNT_W  = clog2_min1(max2(STRETCH, GAP) + 1);
  localparam int HOLD_W = clog2_min1(SW_HOLD + 1);
  localparam int IDX_W  = clog2_min1(NCH);

  stdrst_state_t    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             done, done_next;
  logic [NCH-1:0]   rel_set;   // channel released on this edge
  logic [NCH-1:0]   sw_take;   // software pulse accepted on this edge
  logic [NCH-1:0]   rst_n_q;
  logic             req_s;     // synchronised request
  logic             req_eff;   // request that actually forces ASSERT

  // ---------------------------------------------------------------------------
  // Request synchroniser and optional glitch filter
  // ---------------------------------------------------------------------------
  stdrst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (i_rst_req),
    .q  (req_s)
  );

`ifdef STDRST_GLITCH_FILT_EN
  // filt_cnt counts consecutive high samples seen before the current one and
  // saturates at FILT_LEN-1; the request acts on the FILT_LEN-th high sample.
  localparam int FILT_W = clog2_min1(FILT_LEN);

  logic [FILT_W-1:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
    end else if (!req_s) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_W'(FILT_LEN - 1)) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign req_eff = req_s && (filt_cnt == FILT_W'(FILT_LEN - 1));
`else
  assign req_eff = req_s;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ASSERT;
      cnt   <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      done  <= done_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    done_next  = 1'b0;
    rel_set    = '0;

    if (req_eff) begin
      // A request overrides everything below; while it is held cnt stays 0,
      // so the stretch starts counting on the first cycle after it drops.
      state_next = ASSERT;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt == CNT_W'(STRETCH - 1)) begin
            state_next = REL;
            cnt_next   = '0;
            idx_next   = '0;
            rel_set    = NCH'(1);
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        REL: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            cnt_next = '0;
            if (idx == IDX_W'(NCH - 1)) begin
              state_next = RUN;
              done_next  = 1'b1;
            end else begin
              idx_next = idx + IDX_W'(1);
              rel_set  = NCH'(1) << idx_next;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Idle; per-channel logic handles software resets.
        end

        default: begin
          state_next = ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Software pulses are honoured only once the full sequence has completed.
  assign sw_take = (state == RUN) ? i_sw_rst : '0;

  // ---------------------------------------------------------------------------
  // Per-channel output flop and software-hold counter
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [HOLD_W-1:0] hold_cnt;
    logic              rst_n_r;

    // NOTE: the hold counters are reset explicitly, unlike a data array, because
    // a stale nonzero count would release a channel on its own after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt <= '0;
        rst_n_r  <= 1'b0;
      end else if (req_eff) begin
        hold_cnt <= '0;
        rst_n_r  <= 1'b0;
      end else if (sw_take[k]) begin
        // A new pulse during a hold simply reloads the full hold time.
        hold_cnt <= HOLD_W'(SW_HOLD);
        rst_n_r  <= 1'b0;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) begin
          rst_n_r <= 1'b1;
        end
      end else if (rel_set[k]) begin
        rst_n_r <= 1'b1;
      end
    end

    assign rst_n_q[k] = rst_n_r;
  end

  assign o_rst_n = rst_n_q;
  assign o_busy  = (state != RUN);
  assign o_done  = done;

endmodule

// File: tb/tb_stdrst_seq.sv
// -----------------------------------------------------------------------------
// tb_stdrst_seq
//   Self-checking bench for stdrst_seq at its default parameters. Each test
//   pushes the output expected after every clock edge onto a scoreboard queue
//   as it drives that edge's stimulus, then pops and compares it one time unit
//   after the edge. Expected values come from the release timing formula
//   (channel k up STRETCH+k*GAP edges after the reset source was last seen)
//   and from a per-channel "low until edge" model of the software holds.
//   Define STDRST_GLITCH_FILT_EN for both bench and RTL to cover the filter.
// -----------------------------------------------------------------------------
module tb_stdrst_seq;

  localparam int NCH         = 3;
  localparam int STRETCH     = 4;
  localparam int GAP         = 2;
  localparam int SYNC_STAGES = 2;
  localparam int SW_HOLD     = 8;
  localparam int T_DONE      = STRETCH + NCH * GAP;
`ifdef STDRST_GLITCH_FILT_EN
  localparam int FL = 3;
`else
  localparam int FL = 1;
`endif

  typedef struct packed {
    logic [NCH-1:0] rst_n;
    logic           busy;
    logic           done;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_rst_req;
  logic [NCH-1:0] i_sw_rst;
  logic [NCH-1:0] o_rst_n;
  logic           o_busy;
  logic           o_done;
  obs_t           got;

  obs_t           exp_q[$];
  obs_t           exp_v;
  int             checks   = 0;
  int             failures = 0;
  logic [NCH-1:0] pat [16];

  always #5 clk = ~clk;

  stdrst_seq #(
    .NCH        (NCH),
    .STRETCH    (STRETCH),
    .GAP        (GAP),
    .SYNC_STAGES(SYNC_STAGES),
    .SW_HOLD    (SW_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_rst_req(i_rst_req),
    .i_sw_rst (i_sw_rst),
    .o_rst_n  (o_rst_n),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  assign got = {o_rst_n, o_busy, o_done};

  // Expected outputs n edges after the last edge that saw the reset source.
  // n <= 0 means still in reset; large n means steady RUN.
  function automatic obs_t rel_exp(input int n);
    obs_t e;
    for (int k = 0; k < NCH; k++) e.rst_n[k] = (n >= STRETCH + k * GAP);
    e.busy = (n < T_DONE);
    e.done = (n == T_DONE);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    i_rst_req = 1'b0;
    i_sw_rst  = '0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rel_exp(0));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL reset_hold edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= T_DONE + 2; i++) begin
      exp_q.push_back(rel_exp(i));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL reset_release edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Request pulse of len cycles from RUN. With sw_during, all software reset
  // bits are held high from the edge the request acts until the edge that
  // enters RUN, where they must have no effect.
  task automatic test_req(input string name, input int len, input bit sw_during);
    bit act;
    int first, base, last;
    act   = (len >= FL);
    first = SYNC_STAGES + FL - 1;
    base  = len + SYNC_STAGES - 1;
    last  = act ? base + T_DONE + 2 : len + SYNC_STAGES + FL + 3;
    for (int i = 0; i <= last; i++) begin
      i_rst_req = (i < len);
      i_sw_rst  = (sw_during && act && i >= first && i <= base + T_DONE) ? '1 : '0;
      if (!act || i < first) exp_q.push_back(rel_exp(T_DONE + 1));
      else                   exp_q.push_back(rel_exp(i - base));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL %s edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 name, i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
    i_rst_req = 1'b0;
    i_sw_rst  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Software hold on ch1 interrupted by a request: the hold must be discarded
  // and ch1 must follow the normal release schedule.
  task automatic test_req_clears_hold();
    int first, base;
    first = 1 + SYNC_STAGES + FL - 1;
    base  = 1 + FL + SYNC_STAGES - 1;
    for (int i = 0; i <= base + T_DONE + 2; i++) begin
      i_sw_rst  = (i == 0) ? NCH'(3'b010) : '0;
      i_rst_req = (i >= 1 && i < 1 + FL);
      if (i < first) begin
        exp_v       = rel_exp(T_DONE + 1);
        exp_v.rst_n = 3'b101;
        exp_q.push_back(exp_v);
      end else begin
        exp_q.push_back(rel_exp(i - base));
      end
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL req_clears_hold edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
    i_rst_req = 1'b0;
    i_sw_rst  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Global reset for one cycle while in REL (ch0 already released).
  task automatic test_rst_mid_rel();
    int base, r;
    base = FL + SYNC_STAGES - 1;
    r    = base + STRETCH + 1;
    for (int i = 0; i <= r + T_DONE + 2; i++) begin
      i_rst_req = (i < FL);
      rst       = (i == r);
      if (i < base)      exp_q.push_back(rel_exp(T_DONE + 1));
      else if (i < r)    exp_q.push_back(rel_exp(i - base));
      else               exp_q.push_back(rel_exp(i - r));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL rst_mid_rel edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
    rst       = 1'b0;
    i_rst_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Software reset pattern applied from RUN; a pulse seen at edge i keeps its
  // channel low through edge i+SW_HOLD-1.
  task automatic test_sw(input string name, input logic [NCH-1:0] p [16]);
    int low_until [NCH];
    for (int k = 0; k < NCH; k++) low_until[k] = -1;
    for (int i = 0; i <= 16 + SW_HOLD; i++) begin
      i_sw_rst = (i < 16) ? p[i] : '0;
      for (int k = 0; k < NCH; k++) if (i_sw_rst[k]) low_until[k] = i + SW_HOLD - 1;
      exp_v.busy = 1'b0;
      exp_v.done = 1'b0;
      for (int k = 0; k < NCH; k++) exp_v.rst_n[k] = !(i <= low_until[k]);
      exp_q.push_back(exp_v);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL %s edge %0d: got rst_n=%b busy=%b done=%b, need rst_n=%b busy=%b done=%b",
                 name, i, got.rst_n, got.busy, got.done, exp_v.rst_n, exp_v.busy, exp_v.done);
      end
    end
    i_sw_rst = '0;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 16; i++) pat[i] = '0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();

    clear_pat();
    pat[0] = 3'b010;
    test_sw("sw_single", pat);

    clear_pat();
    pat[0] = 3'b100;
    pat[5] = 3'b100;
    test_sw("sw_repulse", pat);

    clear_pat();
    pat[0]  = 3'b001;
    pat[3]  = 3'b010;
    pat[10] = 3'b011;
    test_sw("sw_multi", pat);

    test_req("req_pulse", FL, 1'b0);
    test_req("req_held", FL + 3, 1'b0);
    test_req("req_sw_ignored", FL, 1'b1);
    test_req_clears_hold();
    test_rst_mid_rel();
`ifdef STDRST_GLITCH_FILT_EN
    test_req("req_glitch", FL - 1, 1'b0);
    test_req("req_filtered", FL, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
